// File: rtl/neureka_normquant_mult_pipe.sv
// N_CH-lane signed norm*accumulator multiplier with optional rounding, arithmetic right shift
// and saturate/wrap to OUT_W, followed by a PIPE-deep elastic valid/ready pipeline.
module neureka_normquant_mult_pipe #(
  parameter int unsigned NMS     = 8,
  parameter int unsigned ACC     = 32,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PIPE    = 1,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [N_CH-1:0][NMS:0]           norm_mult_i,
  input  logic [N_CH-1:0][ACC-1:0]         accumulator_i,
  input  logic [SHIFT_W-1:0]               shift_i,
  input  logic                             round_en_i,
  input  logic                             sat_en_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [N_CH-1:0][OUT_W-1:0]       product_o,
  output logic [N_CH-1:0]                  sat_flag_o
);

  localparam int unsigned W = NMS + 1 + ACC;

  logic [N_CH-1:0][OUT_W-1:0] lane_res;
  logic [N_CH-1:0]            lane_flag;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    logic signed [W-1:0] n_ext, a_ext, prod;
    logic        [W:0]   rnd_add;
    logic signed [W:0]   rounded, shifted, hi;
    logic [OUT_W-1:0]    lim_min, res;
    logic                flag;

    assign n_ext   = {{(W-NMS-1){norm_mult_i[gi][NMS]}}, norm_mult_i[gi]};
    assign a_ext   = {{(W-ACC){accumulator_i[gi][ACC-1]}}, accumulator_i[gi]};
    assign prod    = n_ext * a_ext;
    // One extra bit so the half-LSB addition can never overflow the product range
    assign rnd_add = (round_en_i && shift_i != '0) ? ((W+1)'(1) << (shift_i - SHIFT_W'(1))) : '0;
    assign rounded = {prod[W-1], prod} + rnd_add;
    assign shifted = rounded >>> shift_i;
    // Result fits in OUT_W signed bits iff everything above bit OUT_W-2 is pure sign
    assign hi      = shifted >>> (OUT_W - 1);

    always_comb begin
      lim_min            = '0;
      lim_min[OUT_W-1]   = 1'b1;
      res                = shifted[OUT_W-1:0];
      flag               = 1'b0;
      if (sat_en_i && !((hi == '0) || (&hi))) begin
        flag = 1'b1;
        res  = shifted[W] ? lim_min : ~lim_min;
      end
    end

    assign lane_res[gi]  = res;
    assign lane_flag[gi] = flag;
  end

  if (PIPE == 0) begin : g_comb
    assign valid_o    = valid_i;
    assign ready_o    = ready_i & ~clear_i;
    assign product_o  = lane_res;
    assign sat_flag_o = lane_flag;
  end else begin : g_pipe
    logic [PIPE-1:0]                       v_vec, load, drain;
    logic [PIPE:0]                         down_rdy;
    logic [PIPE-1:0][N_CH-1:0][OUT_W-1:0]  prod_vec;
    logic [PIPE-1:0][N_CH-1:0]             flag_vec;

    // Ready ripples back from the output: a stage can take a beat if empty or draining
    always_comb begin
      load           = '0;
      drain          = '0;
      down_rdy       = '0;
      down_rdy[PIPE] = ready_i;
      for (int k = PIPE - 1; k >= 0; k--) begin
        drain[k]    = v_vec[k] & down_rdy[k+1];
        down_rdy[k] = ~v_vec[k] | drain[k];
      end
      ready_o = ~clear_i & down_rdy[0];
      load[0] = valid_i & ready_o;
      for (int k = 1; k < PIPE; k++) begin
        load[k] = v_vec[k-1] & down_rdy[k];
      end
    end

    for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
      logic                       v_q, v_d;
      logic [N_CH-1:0][OUT_W-1:0] prod_q, prod_d, prod_in;
      logic [N_CH-1:0]            flag_q, flag_d, flag_in;

      if (gi == 0) begin : g_src_in
        assign prod_in = lane_res;
        assign flag_in = lane_flag;
      end else begin : g_src_prev
        assign prod_in = prod_vec[gi-1];
        assign flag_in = flag_vec[gi-1];
      end

      always_comb begin
        v_d    = v_q;
        prod_d = prod_q;
        flag_d = flag_q;
        if (clear_i) begin
          v_d    = 1'b0;
          prod_d = '0;
          flag_d = '0;
        end else if (load[gi]) begin
          v_d    = 1'b1;
          prod_d = prod_in;
          flag_d = flag_in;
        end else if (drain[gi]) begin
          v_d    = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q    <= 1'b0;
          prod_q <= '0;
          flag_q <= '0;
        end else begin
          v_q    <= v_d;
          prod_q <= prod_d;
          flag_q <= flag_d;
        end
      end

      assign v_vec[gi]    = v_q;
      assign prod_vec[gi] = prod_q;
      assign flag_vec[gi] = flag_q;
    end

    assign valid_o    = v_vec[PIPE-1];
    assign product_o  = prod_vec[PIPE-1];
    assign sat_flag_o = flag_vec[PIPE-1];
  end

endmodule

// File: tb/tb_neureka_normquant_mult_pipe.sv
// Directed bench: a PIPE=1/OUT_W=32 and a PIPE=2/OUT_W=16 instance share stimulus.
module tb_neureka_normquant_mult_pipe;

  typedef logic signed [31:0] s32_t;
  typedef struct packed {
    s32_t [0:3] norm;
    s32_t [0:3] acc;
    logic [4:0] shift;
    logic       rnd;
    logic       sat;
    s32_t [0:3] e16;
    logic [3:0] f16;
    s32_t [0:3] e32;
  } vec_t;

  localparam int NV = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, clear, valid_i, ready_i, rnd, sat;
  logic [3:0][8:0]  norm;
  logic [3:0][31:0] acc;
  logic [4:0]       shift;
  logic             p1_ready, p1_valid, p2_ready, p2_valid;
  logic [3:0][31:0] p1_prod;
  logic [3:0][15:0] p2_prod;
  logic [3:0]       p1_flag, p2_flag;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[NV];

  neureka_normquant_mult_pipe #(.PIPE(1), .OUT_W(32)) u_p1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid_i), .ready_o(p1_ready),
    .norm_mult_i(norm), .accumulator_i(acc), .shift_i(shift), .round_en_i(rnd),
    .sat_en_i(sat), .valid_o(p1_valid), .ready_i(ready_i), .product_o(p1_prod),
    .sat_flag_o(p1_flag));

  neureka_normquant_mult_pipe #(.PIPE(2), .OUT_W(16)) u_p2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid_i), .ready_o(p2_ready),
    .norm_mult_i(norm), .accumulator_i(acc), .shift_i(shift), .round_en_i(rnd),
    .sat_en_i(sat), .valid_o(p2_valid), .ready_i(ready_i), .product_o(p2_prod),
    .sat_flag_o(p2_flag));

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic drive_vec(input int i);
    for (int j = 0; j < 4; j++) begin
      norm[j] = vecs[i].norm[j][8:0];
      acc[j]  = vecs[i].acc[j];
    end
    shift = vecs[i].shift;
    rnd   = vecs[i].rnd;
    sat   = vecs[i].sat;
  endtask

  // Simple stream beat: norm 2, acc = 100*b + lane + 1, no shift/round
  task automatic drive_beat(input int b);
    for (int j = 0; j < 4; j++) begin
      norm[j] = 9'd2;
      acc[j]  = 32'(100 * b + j + 1);
    end
    shift = '0;
    rnd   = 1'b0;
    sat   = 1'b1;
  endtask

  task automatic chk_beat(input string name, input int b);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s b%0d l%0d", name, b, j), longint'($signed(p2_prod[j])),
          longint'(2 * (100 * b + j + 1)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx, out_idx, first_out;
    bit stall_prev, drop_seen;

    vecs[0].norm = '{3, -5, 255, -256};        vecs[0].acc = '{-7, 4, 100, -1};
    vecs[0].shift = 5'd0;  vecs[0].rnd = 1'b0; vecs[0].sat = 1'b1;
    vecs[0].e16 = '{-21, -20, 25500, 256};     vecs[0].f16 = 4'b0000;
    vecs[0].e32 = '{-21, -20, 25500, 256};

    vecs[1].norm = '{5, 5, 7, -1};             vecs[1].acc = '{3, -3, 9, 6};
    vecs[1].shift = 5'd2;  vecs[1].rnd = 1'b1; vecs[1].sat = 1'b1;
    vecs[1].e16 = '{4, -4, 16, -1};            vecs[1].f16 = 4'b0000;
    vecs[1].e32 = '{4, -4, 16, -1};

    vecs[2].norm = '{5, 5, 7, -1};             vecs[2].acc = '{3, -3, 9, 6};
    vecs[2].shift = 5'd2;  vecs[2].rnd = 1'b0; vecs[2].sat = 1'b1;
    vecs[2].e16 = '{3, -4, 15, -2};            vecs[2].f16 = 4'b0000;
    vecs[2].e32 = '{3, -4, 15, -2};

    vecs[3].norm = '{100, -100, 1, 1};         vecs[3].acc = '{1000, 1000, 32767, -32768};
    vecs[3].shift = 5'd0;  vecs[3].rnd = 1'b0; vecs[3].sat = 1'b1;
    vecs[3].e16 = '{32767, -32768, 32767, -32768}; vecs[3].f16 = 4'b0011;
    vecs[3].e32 = '{100000, -100000, 32767, -32768};

    vecs[4].norm = '{100, -100, 1, 1};         vecs[4].acc = '{1000, 1000, 32767, -32768};
    vecs[4].shift = 5'd0;  vecs[4].rnd = 1'b0; vecs[4].sat = 1'b0;
    vecs[4].e16 = '{-31072, 31072, 32767, -32768}; vecs[4].f16 = 4'b0000;
    vecs[4].e32 = '{100000, -100000, 32767, -32768};

    vecs[5].norm = '{3, 2, 0, 1};              vecs[5].acc = '{1, -1, 12345, -1};
    vecs[5].shift = 5'd0;  vecs[5].rnd = 1'b1; vecs[5].sat = 1'b1;
    vecs[5].e16 = '{3, -2, 0, -1};             vecs[5].f16 = 4'b0000;
    vecs[5].e32 = '{3, -2, 0, -1};

    vecs[6].norm = '{255, -256, 1, 1};         vecs[6].acc = '{2147483647, 2147483647, -1, 1};
    vecs[6].shift = 5'd31; vecs[6].rnd = 1'b0; vecs[6].sat = 1'b1;
    vecs[6].e16 = '{254, -256, -1, 0};         vecs[6].f16 = 4'b0000;
    vecs[6].e32 = '{254, -256, -1, 0};

    vecs[7].norm = '{255, -256, 1, 1};         vecs[7].acc = '{2147483647, 2147483647, -1, 1};
    vecs[7].shift = 5'd31; vecs[7].rnd = 1'b1; vecs[7].sat = 1'b1;
    vecs[7].e16 = '{255, -256, 0, 0};          vecs[7].f16 = 4'b0000;
    vecs[7].e32 = '{255, -256, 0, 0};

    rst_n = 1'b0; clear = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    norm = '0; acc = '0; shift = '0; rnd = 1'b0; sat = 1'b0;
    #3;
    chk("reset p1 valid_o", p1_valid, 0);
    chk("reset p2 valid_o", p2_valid, 0);
    chk("reset p2 product_o", p2_prod, 0);
    chk("reset p2 sat_flag_o", p2_flag, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beats through both instances
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_vec(i);
      valid_i = 1'b1;
      #1;
      chk($sformatf("v%0d p2 ready_o", i), p2_ready, 1);
      @(negedge clk);
      valid_i = 1'b0;
      chk($sformatf("v%0d p1 valid_o", i), p1_valid, 1);
      chk($sformatf("v%0d p2 valid_o early", i), p2_valid, 0);
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d p1 lane%0d", i, j), longint'($signed(p1_prod[j])),
            longint'(vecs[i].e32[j]));
      chk($sformatf("v%0d p1 sat_flag_o", i), p1_flag, 0);
      @(negedge clk);
      chk($sformatf("v%0d p2 valid_o", i), p2_valid, 1);
      chk($sformatf("v%0d p1 valid_o after", i), p1_valid, 0);
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d p2 lane%0d", i, j), longint'($signed(p2_prod[j])),
            longint'(vecs[i].e16[j]));
      chk($sformatf("v%0d p2 sat_flag_o", i), p2_flag, longint'(vecs[i].f16));
    end

    // Back-to-back stream into PIPE=2 with a 3-cycle output stall
    @(negedge clk);
    in_idx = 0; out_idx = 0; first_out = -1; stall_prev = 1'b0; drop_seen = 1'b0;
    for (int c = 0; c < 30 && out_idx < 4; c++) begin
      @(negedge clk);
      if (stall_prev) chk("stall valid_o held", p2_valid, 1);
      if (p2_valid && first_out < 0) first_out = c;
      ready_i = !(first_out >= 0 && c < first_out + 3);
      if (in_idx < 4) begin
        drive_beat(in_idx);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (p2_valid) chk_beat("stream out", out_idx);
      if (valid_i && !p2_ready && !drop_seen) begin
        drop_seen = 1'b1;
        chk("ready_o drop beats held", in_idx, 2);
      end
      if (p2_valid && ready_i) out_idx++;
      if (valid_i && p2_ready) in_idx++;
      stall_prev = p2_valid && !ready_i;
    end
    valid_i = 1'b0;
    chk("stream beats out", out_idx, 4);
    chk("stream ready_o dropped", drop_seen, 1);

    // Clear on a full pipeline with an input beat offered
    @(negedge clk);
    ready_i = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int b = 5; b < 7; b++) begin
      drive_beat(b);
      valid_i = 1'b1;
      @(negedge clk);
    end
    drive_beat(7);
    clear = 1'b1;
    #1;
    chk("clear p2 full before", p2_valid, 1);
    chk("clear p2 ready_o", p2_ready, 0);
    chk("clear p1 ready_o", p1_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    valid_i = 1'b0;
    chk("clear p2 valid_o", p2_valid, 0);
    chk("clear p2 product_o", p2_prod, 0);
    chk("clear p1 valid_o", p1_valid, 0);
    ready_i = 1'b1;
    drive_beat(8);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("post-clear p2 valid_o early", p2_valid, 0);
    @(negedge clk);
    chk("post-clear p2 valid_o", p2_valid, 1);
    chk_beat("post-clear", 8);

    // Asynchronous reset with two saturating beats in flight
    @(negedge clk);
    ready_i = 1'b0;
    drive_vec(3);
    valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    chk("pre-reset p2 valid_o", p2_valid, 1);
    chk("pre-reset p2 sat_flag_o", p2_flag, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset p2 valid_o", p2_valid, 0);
    chk("async reset p2 product_o", p2_prod, 0);
    chk("async reset p2 sat_flag_o", p2_flag, 0);
    chk("async reset p1 valid_o", p1_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
